// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: drives a one-cycle-latency instruction ROM and
// queues {pc, inst} pairs for the decode stage, with redirect (flush) support.
module inst_fetch_buf #(
  parameter int unsigned      ADDR_W   = 32,
  parameter int unsigned      INST_W   = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_q_pc   [DEPTH];
  logic [INST_W-1:0] r_q_inst [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_pc_inflight;

  logic              w_id_valid;
  logic              w_deq_req;
  logic              w_enq;
  logic              w_deq;
  logic [OCC_W-1:0]  w_occ;

  // Occupancy after this cycle counts the in-flight read as already queued,
  // so an arriving ROM word always has a free slot.
  assign w_id_valid = ~rst & (r_count != '0);
  assign w_deq_req  = w_id_valid & ~stall_i;
  assign w_occ      = OCC_W'(r_count) + OCC_W'(r_inflight) - OCC_W'(w_deq_req);
  assign w_enq      = r_inflight & ~flush_i;
  assign w_deq      = w_deq_req & ~flush_i;

  assign rom_ce_o   = ~rst & ~flush_i & (w_occ < OCC_W'(DEPTH));
  assign rom_addr_o = r_fetch_pc;

  // Head entry presented to decode; zeroed when the queue is empty.
  assign id_valid_o = w_id_valid;
  assign id_pc_o    = w_id_valid ? r_q_pc[r_rptr]   : '0;
  assign id_inst_o  = w_id_valid ? r_q_inst[r_rptr] : '0;

  // Fetch PC, in-flight tracking and circular queue update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_inflight    <= 1'b0;
      r_pc_inflight <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_q_pc[i]   <= '0;
        r_q_inst[i] <= '0;
      end
    end else if (flush_i) begin
      r_fetch_pc <= {new_pc_i[ADDR_W-1:2], 2'b00};
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (rom_ce_o) begin
        r_fetch_pc    <= r_fetch_pc + ADDR_W'(4);
        r_inflight    <= 1'b1;
        r_pc_inflight <= r_fetch_pc;
      end else begin
        r_inflight    <= 1'b0;
      end

      if (w_enq) begin
        r_q_pc[r_wptr]   <= r_pc_inflight;
        r_q_inst[r_wptr] <= rom_data_i;
        r_wptr           <= r_wptr + PTR_W'(1);
      end

      if (w_deq) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end

      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Scoreboard bench for inst_fetch_buf: directed scenarios push the PCs expected
// to leave the buffer; a negedge monitor pops and checks every dequeue.
module tb_inst_fetch_buf;

  logic        clk;
  logic        rst;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  int          checks;
  int          failures;
  logic [31:0] exp_q[$];

  inst_fetch_buf dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_o   (rom_ce_o),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .new_pc_i   (new_pc_i),
    .id_valid_o (id_valid_o),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: word at address A is A | 0xAB000000, one cycle after the read.
  always @(posedge clk) begin
    if (rom_ce_o) rom_data_i <= rom_addr_o | 32'hAB000000;
    else          rom_data_i <= 32'h5A5A5A5A;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one cycle: drive inputs just after the edge, return at negedge.
  task automatic next_cycle(input logic r, input logic s, input logic f, input logic [31:0] np);
    @(posedge clk);
    #1;
    rst      = r;
    stall_i  = s;
    flush_i  = f;
    new_pc_i = np;
    @(negedge clk);
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Monitor: every real dequeue must match the next expected PC/instruction.
  always @(negedge clk) begin
    if (!rst && !flush_i && !stall_i && id_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL deq_unexpected: got pc 0x%08h expected none", id_pc_o);
      end else begin
        logic [31:0] epc;
        epc = exp_q.pop_front();
        if (id_pc_o !== epc || id_inst_o !== (epc | 32'hAB000000)) begin
          failures++;
          $display("FAIL deq: got pc 0x%08h inst 0x%08h expected pc 0x%08h inst 0x%08h",
                   id_pc_o, id_inst_o, epc, epc | 32'hAB000000);
        end
      end
    end
  end

  initial begin
    int nce;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    stall_i  = 1'b0;
    flush_i  = 1'b0;
    new_pc_i = '0;

    // Cold start and steady one-per-cycle streaming.
    repeat (3) next_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_ce", 32'(rom_ce_o), 32'd0);
    chk("rst_valid", 32'(id_valid_o), 32'd0);
    chk("rst_pc", id_pc_o, 32'h0);
    chk("rst_inst", id_inst_o, 32'h0);
    push_seq(32'h0, 8);
    next_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("c0_addr", rom_addr_o, 32'h0);
    chk("c0_ce", 32'(rom_ce_o), 32'd1);
    chk("c0_valid", 32'(id_valid_o), 32'd0);
    next_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("c1_addr", rom_addr_o, 32'h4);
    chk("c1_valid", 32'(id_valid_o), 32'd0);
    next_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("c2_addr", rom_addr_o, 32'h8);
    chk("c2_valid", 32'(id_valid_o), 32'd1);
    chk("c2_pc", id_pc_o, 32'h0);
    repeat (7) next_cycle(1'b0, 1'b0, 1'b0, 32'h0);

    // Fill under stall, drain without bubbles, then flush while full.
    repeat (2) next_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst2_valid", 32'(id_valid_o), 32'd0);
    nce = 0;
    for (int i = 0; i < 8; i++) begin
      next_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      if (rom_ce_o) nce++;
      if (i == 4) chk("fill_ce_stop", 32'(rom_ce_o), 32'd0);
    end
    chk("fill_reads", 32'(nce), 32'd4);
    chk("fill_valid", 32'(id_valid_o), 32'd1);
    chk("fill_ce", 32'(rom_ce_o), 32'd0);
    chk("fill_head", id_pc_o, 32'h0);
    push_seq(32'h0, 5);
    next_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("drain_addr", rom_addr_o, 32'h10);
    chk("drain_ce", 32'(rom_ce_o), 32'd1);
    repeat (4) next_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (6) next_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("full_valid", 32'(id_valid_o), 32'd1);
    chk("full_ce", 32'(rom_ce_o), 32'd0);
    next_cycle(1'b0, 1'b1, 1'b1, 32'h40);
    next_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("fl_full_valid", 32'(id_valid_o), 32'd0);
    chk("fl_full_ce", 32'(rom_ce_o), 32'd1);
    chk("fl_full_addr", rom_addr_o, 32'h40);
    push_seq(32'h40, 3);
    repeat (4) next_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // Flush with a read in flight, back-to-back flushes, address wrap.
    repeat (2) next_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    push_seq(32'h0, 1);
    repeat (3) next_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle(1'b0, 1'b0, 1'b1, 32'h103);
    next_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("fl_if_addr", rom_addr_o, 32'h100);
    chk("fl_if_ce", 32'(rom_ce_o), 32'd1);
    chk("fl_if_valid", 32'(id_valid_o), 32'd0);
    next_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("fl_if_valid2", 32'(id_valid_o), 32'd0);
    push_seq(32'h100, 3);
    next_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("fl_if_pc", id_pc_o, 32'h100);
    repeat (2) next_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle(1'b0, 1'b0, 1'b1, 32'h200);
    next_cycle(1'b0, 1'b0, 1'b1, 32'hFFFFFFF9);
    next_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("b2b_addr", rom_addr_o, 32'hFFFFFFF8);
    chk("b2b_valid", 32'(id_valid_o), 32'd0);
    push_seq(32'hFFFFFFF8, 6);
    next_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr1", rom_addr_o, 32'hFFFFFFFC);
    next_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr2", rom_addr_o, 32'h0);
    repeat (5) next_cycle(1'b0, 1'b0, 1'b0, 32'h0);

    // Reset while count=3 with a read in flight.
    repeat (2) next_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (4) next_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    next_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    next_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("mid_rst_valid", 32'(id_valid_o), 32'd0);
    chk("mid_rst_pc", id_pc_o, 32'h0);
    chk("mid_rst_inst", id_inst_o, 32'h0);
    chk("mid_rst_ce", 32'(rom_ce_o), 32'd1);
    chk("mid_rst_addr", rom_addr_o, 32'h0);
    push_seq(32'h0, 2);
    repeat (3) next_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle(1'b0, 1'b1, 1'b0, 32'h0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_buf.md
INST_FETCH_BUF -- requirements
Module: inst_fetch_buf

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 32, instruction address width.
- INST_W, 32, instruction width.
- DEPTH, 4, prefetch queue entries; power of two, >= 2.
- RESET_PC, 0, first fetch address after reset.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- rom_ce_o  out  1  instruction ROM read enable.
- rom_addr_o  out  ADDR_W  instruction ROM read address.
- rom_data_i  in  INST_W  ROM data; valid the cycle after an accepted read.
- stall_i  in  1  decode stage cannot accept the head entry.
- flush_i  in  1  redirect request; discards all buffered and in-flight fetches.
- new_pc_i  in  ADDR_W  redirect target; sampled when flush_i=1.
- id_valid_o  out  1  head entry present.
- id_pc_o  out  ADDR_W  PC of head entry.
- id_inst_o  out  INST_W  instruction of head entry.

Function
REQ-004 State SHALL be: fetch_pc, circular queue of DEPTH {pc, inst} entries, read/write pointers, occupancy count (clog2(DEPTH)+1 bits), 1-bit inflight flag, pc_inflight register.
REQ-005 rom_addr_o SHALL equal fetch_pc, combinationally.
REQ-006 rom_ce_o SHALL be 1 iff rst=0, flush_i=0, and count + inflight - deq < DEPTH, where deq = id_valid_o & ~stall_i.
REQ-007 When rom_ce_o=1: fetch_pc <= fetch_pc + 4, wrapping modulo 2^ADDR_W; inflight <= 1; pc_inflight <= fetch_pc. Otherwise inflight <= 0.
REQ-008 When inflight=1 and flush_i=0, {pc_inflight, rom_data_i} SHALL be written at the write pointer in that cycle.
REQ-009 The ROM has one-cycle latency, so an instruction SHALL appear on id_* no earlier than 2 cycles after its rom_ce_o cycle.
REQ-010 id_valid_o SHALL be 1 iff count > 0.
REQ-011 id_pc_o and id_inst_o SHALL show the head entry; both SHALL be 0 when count = 0.
REQ-012 Dequeue SHALL occur iff id_valid_o=1, stall_i=0 and flush_i=0.
REQ-013 Simultaneous enqueue and dequeue SHALL leave count unchanged; both pointers advance, wrapping at DEPTH.
REQ-014 With stall_i=0 and no flush, steady-state throughput SHALL be one instruction per cycle for any DEPTH >= 2.
REQ-015 Because of REQ-006, an enqueue SHALL never find the queue full; count SHALL never exceed DEPTH.
REQ-016 flush_i=1 SHALL, in that cycle:
- clear count, pointers and inflight;
- suppress the write of any arriving rom_data_i;
- suppress dequeue;
- load fetch_pc <= {new_pc_i[ADDR_W-1:2], 2'b00}.
REQ-017 In the cycle after a flush, rom_ce_o SHALL be 1 with rom_addr_o equal to the aligned new_pc_i.
REQ-018 Priority SHALL be rst > flush_i > stall_i; stall_i SHALL NOT block fetching while space remains.
REQ-019 Back-to-back flushes SHALL each take effect, the last one defining fetch_pc.

Reset
REQ-020 While rst=1, the block SHALL hold:
- fetch_pc=RESET_PC;
- count=0, pointers=0, inflight=0, queue contents=0;
- rom_ce_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0.
REQ-021 Reset asserted mid-operation SHALL discard queued and in-flight fetches; the first cycle after release SHALL show rom_ce_o=1, rom_addr_o=RESET_PC.

Verification
REQ-022 Cold start, stall_i=0, ROM word at addr A = A|0xAB000000: release rst at cycle 0 -> rom_addr_o = 0, 4, 8 on cycles 0, 1, 2; id_valid_o=1 from cycle 2 with id_pc_o=0, id_inst_o=0xAB000000; then one new PC per cycle.
REQ-023 Fill, DEPTH=4: hold stall_i=1 -> exactly 4 ROM reads (addresses 0x0-0xC); count=4; rom_ce_o=0 thereafter. Release stall -> PCs 0x0, 0x4, 0x8, 0xC, 0x10 dequeue on consecutive cycles with no bubble.
REQ-024 Flush with in-flight read: flush_i=1, new_pc_i=0x103 in the cycle data for 0x8 returns -> 0x8 never appears on id_*; next cycle rom_addr_o=0x100; id_pc_o=0x100 two cycles later.
REQ-025 Flush while stalled and full: count=4, stall_i=1, flush_i=1, new_pc_i=0x40 -> id_valid_o=0 next cycle; queue refills from 0x40.
REQ-026 Wrap-around: RESET_PC=0xFFFFFFF8 -> PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 in order; pointer wrap produces no lost or duplicated entry.
REQ-027 Reset mid-run: assert rst with count=3 and inflight=1 -> all id_* outputs 0 next cycle; after release, fetch restarts at RESET_PC.
